// File: rtl/digit_serial_adder_pkg.sv
// Shared types and size derivations for the digit-serial adder.
// NUM_DIGITS/DIGIT_IDX_W are the default-configuration constants; the functions serve other sizes.
package digit_serial_adder_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic int unsigned calc_num_digits(input int unsigned width,
                                                   input int unsigned digit);
      return width / digit;
   endfunction

   // Index width never drops below one bit, even for a single-digit operand.
   function automatic int unsigned calc_idx_w(input int unsigned num_digits);
      return (num_digits > 1) ? $clog2(num_digits) : 1;
   endfunction

   localparam int unsigned DEF_WIDTH   = 16;
   localparam int unsigned DEF_DIGIT   = 4;
   localparam int unsigned NUM_DIGITS  = calc_num_digits(DEF_WIDTH, DEF_DIGIT);
   localparam int unsigned DIGIT_IDX_W = calc_idx_w(NUM_DIGITS);

endpackage

// File: rtl/digit_adder.sv
// Combinational DIGIT-bit ripple-carry adder built from 1-bit full adders.
// Also exposes the carry into the MSB so the caller can derive signed overflow.
module digit_adder #(
   parameter int unsigned DIGIT = 4
) (
   input  logic [DIGIT-1:0] a,
   input  logic [DIGIT-1:0] b,
   input  logic             cin,
   output logic [DIGIT-1:0] sum,
   output logic             cout,
   output logic             cmsb
);

   always_comb begin : ripple
      logic c;
      c    = cin;
      sum  = '0;
      cmsb = cin;
      for (int i = 0; i < int'(DIGIT); i++) begin
         if (i == int'(DIGIT) - 1) begin
            cmsb = c;
         end
         sum[i] = a[i] ^ b[i] ^ c;
         c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
      end
      cout = c;
   end

endmodule

// File: rtl/digit_serial_adder.sv
// Digit-serial add/subtract: one DIGIT-bit slice per cycle, LSB slice first,
// with valid/ready handshakes on both sides and zero-bubble back-to-back operation.
module digit_serial_adder
   import digit_serial_adder_pkg::*;
#(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned DIGIT = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int unsigned NDIG     = calc_num_digits(WIDTH, DIGIT);
   localparam int unsigned IDXW     = calc_idx_w(NDIG);
   localparam logic [IDXW-1:0] LAST = IDXW'(NDIG - 1);

   state_t           state;
   logic [IDXW-1:0]  idx;
   logic             carry;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;

   logic [DIGIT-1:0] a_dig;
   logic [DIGIT-1:0] b_dig;
   logic [DIGIT-1:0] s_dig;
   logic             c_out;
   logic             c_msb;
   logic             accept;

   assign in_ready = (state == IDLE) || ((state == DONE) && out_ready);
   assign accept   = in_valid && in_ready;

   always_comb begin
      a_dig = '0;
      b_dig = '0;
      for (int i = 0; i < int'(NDIG); i++) begin
         if (idx == IDXW'(i)) begin
            a_dig = a_q[i*DIGIT +: DIGIT];
            b_dig = b_q[i*DIGIT +: DIGIT];
         end
      end
   end

   digit_adder #(
      .DIGIT(DIGIT)
   ) u_digit_adder (
      .a    (a_dig),
      .b    (b_dig),
      .cin  (carry),
      .sum  (s_dig),
      .cout (c_out),
      .cmsb (c_msb)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         idx       <= '0;
         carry     <= 1'b0;
         a_q       <= '0;
         b_q       <= '0;
         sum       <= '0;
         cout      <= 1'b0;
         ovf       <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         unique case (state)
            IDLE: ;
            RUN: begin
               for (int i = 0; i < int'(NDIG); i++) begin
                  if (idx == IDXW'(i)) begin
                     sum[i*DIGIT +: DIGIT] <= s_dig;
                  end
               end
               carry <= c_out;
               if (idx == LAST) begin
                  idx       <= '0;
                  state     <= DONE;
                  out_valid <= 1'b1;
                  cout      <= c_out;
                  ovf       <= c_msb ^ c_out;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
         // Accept overrides the DONE->IDLE move above, giving back-to-back RUN.
         if (accept) begin
            a_q   <= a;
            b_q   <= sub ? ~b : b;
            carry <= sub ? 1'b1 : cin;
            idx   <= '0;
            state <= RUN;
         end
      end
   end

endmodule

// File: tb/tb_digit_serial_adder.sv
// Scoreboard bench for the digit-serial adder (16/4 main instance, 8/1 and 8/8 sweeps).
module tb_digit_serial_adder;

   typedef struct packed {
      logic [15:0] sum;
      logic        cout;
      logic        ovf;
   } res_t;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] a;
   logic [15:0] b;
   logic        cin;
   logic        sub;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] sum;
   logic        cout;
   logic        ovf;

   logic [7:0]  a8;
   logic [7:0]  b8;
   logic        sw_valid;
   logic        sw_oready;
   logic        r1_ready, r1_valid, r1_cout, r1_ovf;
   logic [7:0]  r1_sum;
   logic        r8_ready, r8_valid, r8_cout, r8_ovf;
   logic [7:0]  r8_sum;

   int   total = 0;
   int   bad   = 0;
   res_t sb[$];

   digit_serial_adder #(.WIDTH(16), .DIGIT(4)) u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
      .cin(cin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
      .cout(cout), .ovf(ovf)
   );

   digit_serial_adder #(.WIDTH(8), .DIGIT(1)) u_dut_w8d1 (
      .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(r1_ready), .a(a8), .b(b8),
      .cin(1'b0), .sub(1'b0), .out_valid(r1_valid), .out_ready(sw_oready), .sum(r1_sum),
      .cout(r1_cout), .ovf(r1_ovf)
   );

   digit_serial_adder #(.WIDTH(8), .DIGIT(8)) u_dut_w8d8 (
      .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(r8_ready), .a(a8), .b(b8),
      .cin(1'b0), .sub(1'b0), .out_valid(r8_valid), .out_ready(sw_oready), .sum(r8_sum),
      .cout(r8_cout), .ovf(r8_ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic res_t model(input logic [15:0] x, input logic [15:0] y,
                                  input logic c, input logic s);
      res_t        r;
      logic [15:0] yb;
      logic [16:0] t;
      yb     = s ? ~y : y;
      t      = {1'b0, x} + {1'b0, yb} + 17'(s ? 1'b1 : c);
      r.sum  = t[15:0];
      r.cout = t[16];
      r.ovf  = (x[15] == yb[15]) && (t[15] != x[15]);
      return r;
   endfunction

   task automatic wait_valid(output int n);
      n = 0;
      while (!out_valid && n < 40) begin
         @(posedge clk);
         #1;
         n++;
      end
   endtask

   task automatic check_out(input string tag);
      res_t e;
      if (sb.size() == 0) begin
         check({tag, "_sb_empty"}, 32'd1, 32'd0);
      end else begin
         e = sb.pop_front();
         check({tag, "_valid"}, 32'(out_valid), 32'd1);
         check({tag, "_sum"}, 32'(sum), 32'(e.sum));
         check({tag, "_cout"}, 32'(cout), 32'(e.cout));
         check({tag, "_ovf"}, 32'(ovf), 32'(e.ovf));
      end
   endtask

   task automatic run_op(input string tag, input logic [15:0] x, input logic [15:0] y,
                         input logic c, input logic s);
      int n;
      check({tag, "_rdy"}, 32'(in_ready), 32'd1);
      a = x; b = y; cin = c; sub = s; in_valid = 1'b1;
      sb.push_back(model(x, y, c, s));
      @(posedge clk);
      #1;
      // Scramble inputs while busy; they must be ignored.
      in_valid = 1'b0;
      a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); sub = 1'($urandom);
      check({tag, "_busy"}, 32'(in_ready), 32'd0);
      wait_valid(n);
      check({tag, "_lat"}, 32'(n), 32'd4);
      check_out(tag);
      @(posedge clk);
      #1;
   endtask

   initial begin
      int          n, k, l1, l8, stale;
      logic [17:0] hold;

      rst = 1'b1; in_valid = 1'b1; a = 16'h1111; b = 16'h2222; cin = 1'b0; sub = 1'b0;
      out_ready = 1'b1; a8 = 8'h00; b8 = 8'h00; sw_valid = 1'b0; sw_oready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_sum", 32'(sum), 32'd0);
      check("rst_cout", 32'(cout), 32'd0);
      check("rst_ovf", 32'(ovf), 32'd0);
      rst = 1'b0; in_valid = 1'b0;
      @(posedge clk);
      #1;
      check("rst_ready", 32'(in_ready), 32'd1);

      run_op("carry_wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0);
      run_op("borrow", 16'h0005, 16'h0007, 1'b1, 1'b1);
      run_op("sovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0);
      run_op("cin_add", 16'h00FF, 16'h0F00, 1'b1, 1'b0);
      for (int i = 0; i < 6; i++) begin
         run_op($sformatf("rand%0d", i), 16'($urandom), 16'($urandom),
                1'($urandom), 1'($urandom));
      end

      // Back-pressure, then back-to-back accept on the releasing edge.
      out_ready = 1'b0;
      a = 16'h1111; b = 16'h2222; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
      sb.push_back(model(16'h1111, 16'h2222, 1'b0, 1'b0));
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      wait_valid(n);
      check("bp_lat", 32'(n), 32'd4);
      hold = {sum, cout, ovf};
      repeat (3) begin
         @(posedge clk);
         #1;
         check("bp_hold", 32'({sum, cout, ovf}), 32'(hold));
         check("bp_rdy", 32'(in_ready), 32'd0);
      end
      check_out("bp");
      out_ready = 1'b1;
      a = 16'h1234; b = 16'h1111; in_valid = 1'b1;
      sb.push_back(model(16'h1234, 16'h1111, 1'b0, 1'b0));
      #1;
      check("b2b_rdy", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      check("b2b_valid_drop", 32'(out_valid), 32'd0);
      check("b2b_busy", 32'(in_ready), 32'd0);
      wait_valid(n);
      check("b2b_lat", 32'(n), 32'd4);
      check("b2b_const", 32'(sum), 32'h2345);
      check_out("b2b");
      @(posedge clk);
      #1;

      // Reset two digits into RUN; the aborted op must never produce a result.
      a = 16'h00FF; b = 16'h0101; in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("abort_valid", 32'(out_valid), 32'd0);
      check("abort_rdy", 32'(in_ready), 32'd1);
      check("abort_sum", 32'(sum), 32'd0);
      stale = 0;
      repeat (10) begin
         @(posedge clk);
         #1;
         if (out_valid) stale++;
      end
      check("abort_stale", 32'(stale), 32'd0);
      run_op("recover", 16'hA5A5, 16'h5A5A, 1'b1, 1'b0);

      // Sweep configurations: 8/1 and 8/8, both 0x80+0x80.
      a8 = 8'h80; b8 = 8'h80; sw_valid = 1'b1;
      @(posedge clk);
      #1;
      sw_valid = 1'b0;
      l1 = 0; l8 = 0;
      for (k = 1; k <= 20; k++) begin
         if (l1 == 0 && r1_valid) l1 = k - 1;
         if (l8 == 0 && r8_valid) l8 = k - 1;
         @(posedge clk);
         #1;
      end
      check("w8d1_lat", 32'(l1), 32'd8);
      check("w8d8_lat", 32'(l8), 32'd1);
      check("w8d1_valid", 32'(r1_valid), 32'd1);
      check("w8d1_sum", 32'(r1_sum), 32'h00);
      check("w8d1_cout", 32'(r1_cout), 32'd1);
      check("w8d1_ovf", 32'(r1_ovf), 32'd1);
      check("w8d8_valid", 32'(r8_valid), 32'd1);
      check("w8d8_sum", 32'(r8_sum), 32'h00);
      check("w8d8_cout", 32'(r8_cout), 32'd1);
      check("w8d8_ovf", 32'(r8_ovf), 32'd1);
      sw_oready = 1'b1;
      @(posedge clk);
      #1;
      check("sw_drain", 32'({r1_valid, r8_valid}), 32'd0);
      check("sb_leftover", 32'(sb.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

endmodule

// File: doc/digit_serial_adder.md
DIGIT_SERIAL_ADDER -- requirements
Module: digit_serial_adder

Interface
REQ-001 The module SHALL have the following parameters:
- WIDTH, default 16: operand width in bits.
- DIGIT, default 4: bits processed per cycle; WIDTH SHALL be an integer multiple of DIGIT.
REQ-002 The module SHALL have the following ports:
- clk  in  1  sole clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operands a, b, cin, sub valid.
- in_ready  out  1  block can accept operands.
- a  in  WIDTH  addend / minuend.
- b  in  WIDTH  addend / subtrahend.
- cin  in  1  carry-in; used only when sub=0.
- sub  in  1  0: a+b+cin; 1: a-b (a+~b+1).
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- sum  out  WIDTH  result, modulo 2^WIDTH.
- cout  out  1  carry out of MSB (for sub=1, 1 means no borrow).
- ovf  out  1  signed two's-complement overflow.

Function
REQ-003 The block SHALL be a three-state FSM: IDLE, RUN, DONE.
REQ-004 Input handshake: an operation SHALL be accepted on a rising edge where in_valid and in_ready are both 1; a, b, cin and sub SHALL be registered at that edge.
REQ-005 in_ready SHALL be 1 in IDLE, 1 in DONE when out_ready=1, and 0 otherwise (including all of RUN).
REQ-006 On accept, the FSM SHALL go to RUN with digit index 0 and the carry register loaded with (sub ? 1 : cin); the effective b SHALL be (sub ? ~b : b).
REQ-007 In RUN, each cycle SHALL add one DIGIT-bit slice, least significant slice first, with the registered carry, write the slice result into sum, update the carry, and increment the digit index.
REQ-008 After NUM_DIGITS = WIDTH/DIGIT RUN cycles the FSM SHALL enter DONE, so out_valid rises exactly NUM_DIGITS edges after the accept edge.
REQ-009 In DONE, cout SHALL equal the final carry out of bit WIDTH-1.
REQ-010 In DONE, ovf SHALL equal (carry into bit WIDTH-1) XOR (carry out of bit WIDTH-1).
REQ-011 out_valid SHALL be 1 only in DONE.
REQ-012 sum, cout and ovf SHALL hold stable while out_valid=1 and out_ready=0 (back-pressure, no limit on duration).
REQ-013 Output handshake completes on an edge with out_valid=1 and out_ready=1. If in_valid=1 on that same edge, the new operation SHALL be accepted and the FSM SHALL go directly to RUN (no bubble); otherwise the FSM SHALL go to IDLE.
REQ-014 Inputs a, b, cin and sub SHALL be ignored whenever in_ready=0.
REQ-015 Digit index wrap: the index SHALL count 0..NUM_DIGITS-1 and SHALL be reset to 0 on every accept.
REQ-016 The DIGIT=WIDTH configuration SHALL be legal, with a latency of 1 RUN cycle.

Reset
REQ-017 While rst=1 at a rising edge, the FSM SHALL go to IDLE and SHALL clear the digit index, carry, sum, cout, ovf and out_valid to 0.
REQ-018 rst SHALL take priority over any handshake.
REQ-019 Reset mid-RUN or in DONE SHALL abort the operation, and no out_valid SHALL be produced for the aborted operation.
REQ-020 in_ready SHALL be 1 on the first cycle after reset deasserts.

Structure
REQ-021 A shared package SHALL hold the FSM state enum (IDLE/RUN/DONE).
REQ-022 The same shared package SHALL hold the NUM_DIGITS derivation and a DIGIT_IDX_W = $clog2(NUM_DIGITS) constant (minimum 1).
REQ-023 One combinational sub-module, digit_adder, SHALL be parametrised by DIGIT, built as a ripple chain of 1-bit full adders.
REQ-024 digit_adder SHALL output the slice sum, the carry out, and the carry into its MSB (used for ovf).

Verification (WIDTH=16, DIGIT=4 unless stated)
REQ-025 Carry wrap: a=0xFFFF, b=0x0001, cin=0, sub=0 -> sum=0x0000, cout=1, ovf=0, out_valid exactly 4 edges after accept.
REQ-026 Borrow: a=0x0005, b=0x0007, sub=1, cin=1 (ignored) -> sum=0xFFFE, cout=0, ovf=0.
REQ-027 Signed overflow: a=0x7FFF, b=0x0001, cin=0, sub=0 -> sum=0x8000, cout=0, ovf=1.
REQ-028 Back-pressure: hold out_ready=0 for 3 cycles in DONE -> outputs stable and in_ready=0; then out_ready=1 with in_valid=1 (a=0x1234, b=0x1111) -> accepted on the same edge, next result sum=0x2345 after 4 more edges.
REQ-029 Reset mid-RUN: assert rst after 2 digits -> next cycle IDLE, out_valid=0, in_ready=1, sum=0; no stale result appears.
REQ-030 Parameter sweep, WIDTH=8 DIGIT=1: 0x80+0x80 -> sum=0x00, cout=1, ovf=1 after 8 edges.
REQ-031 Parameter sweep, WIDTH=8 DIGIT=8: 0x80+0x80 -> sum=0x00, cout=1, ovf=1 after 1 edge.
